// File: rtl/sdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdiv_pkg
// Description : Shared types and helpers for the sequential signed divider.
// Revision    : 1.0 - initial release
// ============================================================================
package sdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } sdiv_state_t;

    // Iteration counter must hold values 0..width
    function automatic int sdiv_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic logic [63:0] sdiv_most_neg(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdiv_step.sv
`default_nettype none
// ============================================================================
// Module      : sdiv_step
// Description : One combinational restoring-division step on magnitudes.
// Revision    : 1.0 - initial release
// ============================================================================
module sdiv_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_dvd_bit,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q_bit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // Partial remainder stays below the divisor, so WIDTH+1 bits never overflow
    assign w_shift = {i_rem, i_dvd_bit};
    assign w_diff  = w_shift - {1'b0, i_dvs};
    assign o_q_bit = ~w_diff[WIDTH];
    assign o_rem   = o_q_bit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/sdiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : sdiv_seq
// Description : Multi-cycle signed divider, one quotient bit per clock.
//               Optional SDIV_OVF_FLAG_EN adds the ovf output.
// Revision    : 1.0 - initial release
// ============================================================================
module sdiv_seq
    import sdiv_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic [DATAWIDTH-1:0] quot,
    output logic [DATAWIDTH-1:0] rem,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero
`ifdef SDIV_OVF_FLAG_EN
    ,
    output logic                 ovf
`endif
);

    localparam int                    c_CNT_W    = sdiv_cnt_width(DATAWIDTH);
    localparam logic [c_CNT_W-1:0]    c_LAST     = c_CNT_W'(DATAWIDTH - 1);
    localparam logic [63:0]           c_NEG_WIDE = sdiv_most_neg(DATAWIDTH);
    localparam logic [DATAWIDTH-1:0]  c_MOST_NEG = c_NEG_WIDE[DATAWIDTH-1:0];

    if (DATAWIDTH < 2) begin : g_width_check
        $error("sdiv_seq: DATAWIDTH must be at least 2");
    end

    sdiv_state_t            r_state;
    logic [DATAWIDTH-1:0]   r_rem;
    logic [DATAWIDTH-1:0]   r_dvd;
    logic [DATAWIDTH-1:0]   r_dvs;
    logic [DATAWIDTH-1:0]   r_a;
    logic                   r_neg_q;
    logic                   r_neg_r;
    logic                   r_b_zero;
    logic [c_CNT_W-1:0]     r_cnt;

    logic [DATAWIDTH-1:0]   w_abs_a;
    logic [DATAWIDTH-1:0]   w_abs_b;
    logic [DATAWIDTH-1:0]   w_rem_nxt;
    logic                   w_qbit;

    // Unsigned magnitude of the most-negative value is exactly 2^(W-1)
    assign w_abs_a = a[DATAWIDTH-1] ? -a : a;
    assign w_abs_b = b[DATAWIDTH-1] ? -b : b;

    sdiv_step #(
        .WIDTH (DATAWIDTH)
    ) u_step (
        .i_rem     (r_rem),
        .i_dvd_bit (r_dvd[DATAWIDTH-1]),
        .i_dvs     (r_dvs),
        .o_rem     (w_rem_nxt),
        .o_q_bit   (w_qbit)
    );

`ifdef SDIV_OVF_FLAG_EN
    logic r_ovf_case;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_ovf_case <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_ovf_case <= (a == c_MOST_NEG) && (b == '1);
            end
            if (r_state == FIN) begin
                ovf <= r_ovf_case;
            end
        end
    end
`endif

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_a         <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_b_zero    <= 1'b0;
            r_cnt       <= '0;
            quot        <= '0;
            rem         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rem    <= '0;
                        r_dvd    <= w_abs_a;
                        r_dvs    <= w_abs_b;
                        r_a      <= a;
                        r_neg_q  <= a[DATAWIDTH-1] ^ b[DATAWIDTH-1];
                        r_neg_r  <= a[DATAWIDTH-1];
                        r_b_zero <= (b == '0);
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    // Dividend shifts out at the top while quotient bits fill in below
                    r_rem <= w_rem_nxt;
                    r_dvd <= {r_dvd[DATAWIDTH-2:0], w_qbit};
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    quot        <= r_b_zero ? '1  : (r_neg_q ? -r_dvd : r_dvd);
                    rem         <= r_b_zero ? r_a : (r_neg_r ? -r_rem : r_rem);
                    div_by_zero <= r_b_zero;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdiv_seq
// Description : Directed self-checking bench for sdiv_seq at DATAWIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdiv_seq;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [7:0] quot;
    logic [7:0] rem;
    logic       busy;
    logic       done;
    logic       div_by_zero;
`ifdef SDIV_OVF_FLAG_EN
    logic       ovf;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 Clk = ~Clk;

    sdiv_seq #(
        .DATAWIDTH (8)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .start       (start),
        .a           (a),
        .b           (b),
        .quot        (quot),
        .rem         (rem),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
`ifdef SDIV_OVF_FLAG_EN
        ,
        .ovf         (ovf)
`endif
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] eq, input logic [7:0] er, input logic edz);
        string t;
        t = $sformatf("%0d/%0d", $signed(av), $signed(bv));
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        chk({t, " busy@E0"}, {7'd0, busy}, 8'd1);
        start = 1'b0;
        a = 8'h5A;
        b = 8'h33;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("%s busy/done@E%0d", t, i), {6'd0, busy, done}, 8'b10);
        end
        tick();
        chk({t, " done@E9"}, {6'd0, busy, done}, 8'b01);
        chk({t, " quot"}, quot, eq);
        chk({t, " rem"}, rem, er);
        chk({t, " dz"}, {7'd0, div_by_zero}, {7'd0, edz});
        tick();
        chk({t, " done@E10"}, {7'd0, done}, 8'd0);
        chk({t, " quot held"}, quot, eq);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("reset quot", quot, 8'd0);
        chk("reset rem", rem, 8'd0);
        chk("reset busy/done/dz", {5'd0, busy, done, div_by_zero}, 8'd0);
`ifdef SDIV_OVF_FLAG_EN
        chk("reset ovf", {7'd0, ovf}, 8'd0);
`endif
        @(negedge Clk);
        Rst = 1'b1;

        run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        run_op(8'(-100), 8'd7, 8'(-14), 8'(-2), 1'b0);

        // Abort an operation mid-CALC with an asynchronous reset
        a = 8'd100;
        b = 8'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        Rst = 1'b0;
        #1;
        chk("abort quot", quot, 8'd0);
        chk("abort rem", rem, 8'd0);
        chk("abort busy/done/dz", {5'd0, busy, done, div_by_zero}, 8'd0);
        @(negedge Clk);
        Rst = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick();
            chk($sformatf("abort no done %0d", i), {6'd0, busy, done}, 8'd0);
        end
        run_op(8'd50, 8'd6, 8'd8, 8'd2, 1'b0);

        run_op(8'd100, 8'(-7), 8'(-14), 8'd2, 1'b0);
        run_op(8'(-100), 8'(-7), 8'd14, 8'(-2), 1'b0);
        run_op(8'h80, 8'hFF, 8'h80, 8'd0, 1'b0);
`ifdef SDIV_OVF_FLAG_EN
        chk("ovf -128/-1", {7'd0, ovf}, 8'd1);
`endif
        run_op(8'd5, 8'd1, 8'd5, 8'd0, 1'b0);
`ifdef SDIV_OVF_FLAG_EN
        chk("ovf 5/1", {7'd0, ovf}, 8'd0);
`endif
        run_op(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1);
        run_op(8'd9, 8'd3, 8'd3, 8'd0, 1'b0);
        run_op(8'h80, 8'd1, 8'h80, 8'd0, 1'b0);
        run_op(8'd3, 8'h80, 8'd0, 8'd3, 1'b0);
        run_op(8'hFF, 8'd2, 8'd0, 8'hFF, 1'b0);

        // Back-to-back with start held high; operand change at E3 must not disturb op 1
        a = 8'd100;
        b = 8'd7;
        start = 1'b1;
        tick();
        chk("b2b busy@E0", {7'd0, busy}, 8'd1);
        repeat (3) tick();
        a = 8'd50;
        b = 8'd6;
        for (int i = 4; i <= 8; i++) begin
            tick();
            chk($sformatf("b2b op1 busy/done@E%0d", i), {6'd0, busy, done}, 8'b10);
        end
        tick();
        chk("b2b op1 done@E9", {6'd0, busy, done}, 8'b01);
        chk("b2b op1 quot", quot, 8'd14);
        chk("b2b op1 rem", rem, 8'd2);
        tick();
        chk("b2b op2 accept@E10", {6'd0, busy, done}, 8'b10);
        start = 1'b0;
        repeat (8) tick();
        chk("b2b op2 no done@E18", {7'd0, done}, 8'd0);
        tick();
        chk("b2b op2 done@E19", {6'd0, busy, done}, 8'b01);
        chk("b2b op2 quot", quot, 8'd8);
        chk("b2b op2 rem", rem, 8'd2);
        chk("b2b op2 dz", {7'd0, div_by_zero}, 8'd0);
        tick();
        chk("b2b done@E20", {6'd0, busy, done}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdiv_seq.md
Name: sdiv_seq

Overview:
- Multi-cycle signed divider for the datapath component library, one quotient bit per clock.
- Produces quotient and remainder with a one-cycle done strobe.
- Sits directly upstream of the signed pipeline register; done drives that register's load path.
- Replaces the large single-cycle combinational divide where timing cannot close.

Parameters:
DATAWIDTH, 8, operand and result width in bits, two's complement, minimum 2

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request; sampled only in IDLE
a  input  DATAWIDTH  signed dividend, captured on the accepting edge
b  input  DATAWIDTH  signed divisor, captured on the accepting edge
quot  output  DATAWIDTH  signed quotient, held until the next result edge
rem  output  DATAWIDTH  signed remainder, held until the next result edge
busy  output  1  high while an operation is in flight
done  output  1  single-cycle pulse; quot/rem valid
div_by_zero  output  1  qualifies current quot/rem; updated on every result edge

Behaviour:
- Reset (Rst low, asynchronous):
  - State goes to IDLE.
  - quot, rem, busy, done, div_by_zero and all internal registers go to 0.
  - Takes effect immediately, including mid-operation; the in-flight operation is discarded with no done.
- States:
  - IDLE: if start=1 at edge E0, capture a and b, load |a| and |b| as unsigned DATAWIDTH magnitudes, record signs, clear the iteration counter, go to CALC, busy=1. If start=0, stay in IDLE.
  - CALC: at each edge E1..E_DATAWIDTH, perform one restoring step (shift partial remainder left, bring in next dividend MSB, subtract divisor magnitude if result is non-negative, shift quotient bit in) and increment the counter. After the step at E_DATAWIDTH, go to FIN.
  - FIN: at edge E_DATAWIDTH+1, apply sign fix-up, load quot/rem/div_by_zero, set done=1, busy=0, return to IDLE.
- done timing: done is high only for the cycle between E_DATAWIDTH+1 and E_DATAWIDTH+2.
- Latency is fixed at DATAWIDTH+1 edges from the accepting edge, independent of operand values.
- Throughput:
  - start is ignored while busy=1; no queueing.
  - A new start may be accepted at E_DATAWIDTH+2 while done is still high (back-to-back).
  - a and b may change freely after E0.
- Sign rules: truncation toward zero, identical to Verilog signed / and %.
  - quot sign = sign(a) XOR sign(b).
  - rem sign = sign(a).
  - Zero results are never negative.
- Overflow: a = most-negative, b = -1 gives quot = most-negative (two's-complement wrap), rem = 0.
- Most-negative magnitude (2^(DATAWIDTH-1)) is representable as unsigned DATAWIDTH; no extra bit is needed.
- Divide by zero (b = 0):
  - Full latency is still used.
  - Result edge forces quot = all ones (-1), rem = a, div_by_zero = 1.
  - div_by_zero = 0 on every non-zero-divisor result.
- Outputs change only on result edges or on reset.

Optional Feature:
- Macro: SDIV_OVF_FLAG_EN
- Defined: adds output port ovf (1 bit). It is loaded on the result edge, 1 only when a = most-negative and b = -1, else 0. Reset value 0.
- Undefined: no ovf port and no extra logic. Overflow case still wraps as specified.

Decomposition:
- Shared package sdiv_pkg holds:
  - state typedef {IDLE, CALC, FIN} (2-bit encoding)
  - counter width constant $clog2(DATAWIDTH+1)
  - helper function for the most-negative constant per width
- One sub-module, sdiv_step: purely combinational restoring step.
  - Inputs: partial remainder, dividend bit, divisor magnitude.
  - Outputs: next remainder, quotient bit.
  - Instantiated once inside the CALC datapath.

Test Plan (DATAWIDTH=8):
- a=100, b=7, start at E0 -> done high after E9 only, quot=14, rem=2, div_by_zero=0, busy high E0..E9.
- a=-100/b=7 -> quot=-14, rem=-2; a=100/b=-7 -> quot=-14, rem=2; a=-100/b=-7 -> quot=14, rem=-2.
- a=-128, b=-1 -> quot=-128 (8'h80), rem=0; with SDIV_OVF_FLAG_EN, ovf=1 for the result, and ovf=0 for the next op 5/1.
- a=5, b=0 -> after E9 quot=8'hFF, rem=5, div_by_zero=1; next op 9/3 gives quot=3, rem=0, div_by_zero=0.
- start held high continuously and a/b changed at E3 -> E3 change ignored; back-to-back ops accepted at E0 and E10, done pulses after E9 and E19, each result matching its captured operands.
- Rst pulled low at E4 mid-CALC, released, then 50/6 started -> all outputs 0 immediately, no done for the aborted op, new op gives quot=8, rem=2 with full latency.
